// File: rtl/rv32_bus_sequencer.sv
// Splits RV32 core load/store/fetch requests into byte cycles on an 8-bit 65xx-style bus,
// assembling little-endian load data with sign/zero extension and honouring RDY/AEC stalls.
module rv32_bus_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic        req_fetch,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    input  logic        rdy,
    input  logic        rdy_writes,
    input  logic        aec,
    output logic [15:0] bus_addr,
    output logic        bus_rwn,
    output logic [7:0]  bus_dout,
    output logic        bus_doe,
    input  logic [7:0]  bus_din,
    output logic        bus_sync,
    output logic        bus_mln
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [1:0]  last_q, last_d;
    logic        we_q, we_d;
    logic        sgn_q, sgn_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;

    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic        bus_rwn_q, bus_rwn_d;
    logic [7:0]  bus_dout_q, bus_dout_d;
    logic        bus_doe_q, bus_doe_d;
    logic        bus_sync_q, bus_sync_d;
    logic        bus_mln_q, bus_mln_d;

    logic        stall;
    logic [1:0]  req_last;
    logic [1:0]  next_k;
    logic [7:0]  next_dout;
    logic [31:0] merged;
    logic [31:0] loaded;

    always_comb begin
        stall = !aec || (!rdy && (!we_q || rdy_writes));

        case (req_size)
            2'd0:    req_last = 2'd0;
            2'd1:    req_last = 2'd1;
            default: req_last = 2'd3;
        endcase

        next_k = k_q + 2'd1;
        case (next_k)
            2'd0:    next_dout = wdata_q[7:0];
            2'd1:    next_dout = wdata_q[15:8];
            2'd2:    next_dout = wdata_q[23:16];
            default: next_dout = wdata_q[31:24];
        endcase

        // The completing byte is merged combinationally so the result is ready on the same edge.
        merged = rbuf_q;
        case (k_q)
            2'd0:    merged[7:0]   = bus_din;
            2'd1:    merged[15:8]  = bus_din;
            2'd2:    merged[23:16] = bus_din;
            default: merged[31:24] = bus_din;
        endcase

        case (last_q)
            2'd0:    loaded = sgn_q ? {{24{merged[7]}}, merged[7:0]} : {24'd0, merged[7:0]};
            2'd1:    loaded = sgn_q ? {{16{merged[15]}}, merged[15:0]} : {16'd0, merged[15:0]};
            default: loaded = merged;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        last_d      = last_q;
        we_d        = we_q;
        sgn_d       = sgn_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        bus_addr_d  = bus_addr_q;
        bus_rwn_d   = bus_rwn_q;
        bus_dout_d  = bus_dout_q;
        bus_doe_d   = bus_doe_q;
        bus_sync_d  = bus_sync_q;
        bus_mln_d   = bus_mln_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d    = XFER;
                    k_d        = 2'd0;
                    last_d     = req_last;
                    we_d       = req_we;
                    sgn_d      = req_signed;
                    wdata_d    = req_wdata;
                    rbuf_d     = 32'd0;
                    bus_addr_d = req_addr;
                    bus_rwn_d  = !req_we;
                    bus_doe_d  = req_we;
                    bus_dout_d = req_wdata[7:0];
                    bus_sync_d = req_fetch;
                    bus_mln_d  = (req_last == 2'd0);
                end
            end
            XFER: begin
                // A stalled edge falls through with every register holding.
                if (!stall) begin
                    if (!we_q) begin
                        rbuf_d = merged;
                    end
                    if (k_q == last_q) begin
                        state_d     = IDLE;
                        k_d         = 2'd0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = we_q ? 32'd0 : loaded;
                        bus_rwn_d   = 1'b1;
                        bus_doe_d   = 1'b0;
                        bus_dout_d  = 8'd0;
                        bus_sync_d  = 1'b0;
                        bus_mln_d   = 1'b1;
                    end else begin
                        k_d        = next_k;
                        bus_addr_d = bus_addr_q + 16'd1;
                        bus_dout_d = next_dout;
                        bus_sync_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            last_q      <= 2'd0;
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            wdata_q     <= 32'd0;
            rbuf_q      <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            bus_addr_q  <= 16'd0;
            bus_rwn_q   <= 1'b1;
            bus_dout_q  <= 8'd0;
            bus_doe_q   <= 1'b0;
            bus_sync_q  <= 1'b0;
            bus_mln_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            last_q      <= last_d;
            we_q        <= we_d;
            sgn_q       <= sgn_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            bus_addr_q  <= bus_addr_d;
            bus_rwn_q   <= bus_rwn_d;
            bus_dout_q  <= bus_dout_d;
            bus_doe_q   <= bus_doe_d;
            bus_sync_q  <= bus_sync_d;
            bus_mln_q   <= bus_mln_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_addr  = bus_addr_q;
    assign bus_rwn   = bus_rwn_q;
    assign bus_dout  = bus_dout_q;
    assign bus_doe   = bus_doe_q;
    assign bus_sync  = bus_sync_q;
    assign bus_mln   = bus_mln_q;

endmodule

// File: doc/rv32_bus_sequencer.md
# rv32_bus_sequencer

Sequences 8/16/32-bit load, store and instruction-fetch requests from the RV32 execution core into individual byte cycles on the 8-bit, 16-bit-address 65xx-style external bus. It owns the byte counter, address increment, little-endian byte assembly and sign/zero extension, and the RDY/AEC stall rules. It sits between the core's memory request port and the chip-level bus pins (A, D, RWn, SYNC, MLn).

## Interface
Parameters:
- none; bus address width fixed at 16 and data width at 8.

Ports:
- clk  in  1  bus-cycle clock; rising edge = end of bus cycle (parent wires the phase-2-end edge).
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  core request present.
- req_ready  out  1  high when the sequencer can accept a request, i.e. when in IDLE.
- req_we  in  1  1 = store, 0 = load/fetch.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved and treated as word.
- req_signed  in  1  sign-extend byte/half loads. Ignored for words and stores.
- req_fetch  in  1  instruction fetch; drives bus_sync on byte 0.
- req_addr  in  16  byte address of least-significant byte.
- req_wdata  in  32  store data, little-endian.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result, extended. 0 for stores.
- rdy  in  1  bus ready, already synchronised upstream if required.
- rdy_writes  in  1  1 = rdy also stalls write cycles. 0 = writes ignore rdy.
- aec  in  1  bus granted. Low stalls every cycle.
- bus_addr  out  16  byte address.
- bus_rwn  out  1  1 = read.
- bus_dout  out  8  write data.
- bus_doe  out  1  data bus output enable.
- bus_din  in  8  read data, sampled at clk rise.
- bus_sync  out  1  opcode-fetch marker.
- bus_mln  out  1  low while a multi-byte access is in progress.

## Operation
- States: IDLE, XFER.
- IDLE:
  - req_ready = 1.
  - bus_rwn = 1, bus_doe = 0, bus_sync = 0, bus_mln = 1.
  - bus_addr holds its last value (0x0000 after reset).
- Accept occurs on a rising edge with req_valid && req_ready. On accept, latch addr, we, size, signed, fetch and wdata; clear the byte index k; go to XFER.
- XFER, byte cycle k (N = 1, 2 or 4):
  - bus_addr = (addr + k) mod 2^16; wraps from 0xFFFF to 0x0000.
  - bus_rwn = !we. bus_doe = we. bus_dout = wdata[8k+7:8k].
  - bus_sync = fetch && k == 0.
  - bus_mln = 0 when N > 1, else 1.
- Stall condition: stall = !aec || (!rdy && (!we || rdy_writes)). On a stalled edge nothing changes, and all bus outputs hold.
- Non-stalled edge:
  - For a load, bus_din is captured into byte lane k.
  - If k == N-1, go to IDLE and pulse rsp_valid. Otherwise increment k.
- Load result:
  - Bytes are assembled little-endian.
  - Byte and half loads are sign-extended from bit 7/15 when req_signed = 1, else zero-extended.
  - Unused lanes are never driven from stale data.
- No alignment restriction: a misaligned half or word is just consecutive bytes.
- Reset is synchronous:
  - Any edge with rst_n = 0 forces IDLE and k = 0.
  - Outputs return to reset values: bus_addr 0x0000, bus_rwn 1, bus_dout 0x00, bus_doe 0, bus_sync 0, bus_mln 1, rsp_valid 0, rsp_rdata 0, req_ready 1 after the reset edge.
  - An in-flight request is dropped with no rsp_valid.

## Timing
- Accept at edge E0. Byte k occupies the cycle between E(k) and E(k+1) when there are no stalls.
- rsp_valid is high for exactly the cycle after edge E(N), and rsp_rdata is valid in that cycle.
- Latency with no stalls: byte 2 cycles, half 3, word 5 from the accept cycle. Each stalled edge adds 1.
- req_ready is high during the rsp_valid cycle, so back-to-back requests run without bus idle cycles beyond that one.
- rsp_rdata holds its value until the next completion.
- Simultaneous events:
  - Reset wins over accept and completion.
  - aec low during a write stalls even when rdy_writes = 0.
- req_* inputs are ignored outside the accept edge.

## Test plan
- Word load at 0x1234, memory 0x11,0x22,0x33,0x44, rdy = aec = 1:
  - bus_addr sequence 1234, 1235, 1236, 1237.
  - bus_mln = 0 on all four bytes.
  - rsp_valid 5 cycles after accept with rsp_rdata = 0x44332211.
- Signed byte load 0x80 -> rsp_rdata = 0xFFFFFF80. Unsigned -> 0x00000080. Signed half 0x7FFF -> 0x00007FFF.
- Half store 0xBEEF at 0xFFFF:
  - bus_addr FFFF then 0000, bus_dout EF then BE, bus_rwn = 0, bus_doe = 1.
  - rsp_valid with rdata 0.
- Word store with rdy = 0 for 3 cycles:
  - rdy_writes = 0 -> completes in 4 byte cycles.
  - rdy_writes = 1 -> takes 7, with outputs held during the stall.
- Fetch at 0xFFFC with aec low for 2 cycles on byte 1:
  - bus_sync high only on byte 0.
  - Bus outputs frozen while aec = 0.
  - Completion delayed by 2 cycles.
- rst_n low for one edge during byte 2 of a word load:
  - Next cycle IDLE, req_ready = 1, bus_addr 0x0000, bus_rwn 1.
  - No rsp_valid.
  - A new byte load then completes normally.
